// File: rtl/ps2_kbd_ascii.sv
// ps2_kbd_ascii
// -------------
// Receives PS/2 set-2 scancodes from a keyboard and tracks the make/break,
// extended-prefix, Shift and Caps Lock state. Make codes are translated to
// US-layout ASCII and queued in a small FIFO. The FIFO head is offered to the
// memory controller with a level interrupt and an acknowledge-to-pop handshake.
//
// Ports:
//   clk50M        in   system clock
//   rst           in   synchronous reset, active-low
//   ps2_clk       in   raw PS/2 clock (asynchronous)
//   ps2_data      in   raw PS/2 data (asynchronous)
//   kbd_int       out  high while the FIFO holds at least one byte
//   kbd_data      out  ASCII byte at the FIFO head, 0x00 when empty
//   kbd_int_ack   in   consumer acknowledge; a rising edge pops the head
//   kbd_overflow  out  sticky: a translated byte was dropped on a full FIFO
//   kbd_frame_err out  one-cycle pulse on start/parity/stop/timeout error
module ps2_kbd_ascii #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kbd_int,
    output logic [7:0] kbd_data,
    input  logic       kbd_int_ack,
    output logic       kbd_overflow,
    output logic       kbd_frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    // US-layout lowercase letter for a set-2 make code, 0x00 if not a letter.
    function automatic logic [7:0] letter_lc(input logic [7:0] code);
        case (code)
            8'h1C: letter_lc = 8'h61; 8'h32: letter_lc = 8'h62;
            8'h21: letter_lc = 8'h63; 8'h23: letter_lc = 8'h64;
            8'h24: letter_lc = 8'h65; 8'h2B: letter_lc = 8'h66;
            8'h34: letter_lc = 8'h67; 8'h33: letter_lc = 8'h68;
            8'h43: letter_lc = 8'h69; 8'h3B: letter_lc = 8'h6A;
            8'h42: letter_lc = 8'h6B; 8'h4B: letter_lc = 8'h6C;
            8'h3A: letter_lc = 8'h6D; 8'h31: letter_lc = 8'h6E;
            8'h44: letter_lc = 8'h6F; 8'h4D: letter_lc = 8'h70;
            8'h15: letter_lc = 8'h71; 8'h2D: letter_lc = 8'h72;
            8'h1B: letter_lc = 8'h73; 8'h2C: letter_lc = 8'h74;
            8'h3C: letter_lc = 8'h75; 8'h2A: letter_lc = 8'h76;
            8'h1D: letter_lc = 8'h77; 8'h22: letter_lc = 8'h78;
            8'h35: letter_lc = 8'h79; 8'h1A: letter_lc = 8'h7A;
            default: letter_lc = 8'h00;
        endcase
    endfunction

    // {plain, shifted} character for non-letter keys, 0 if unmapped.
    function automatic logic [15:0] other_pair(input logic [7:0] code);
        case (code)
            8'h16: other_pair = 16'h3121; 8'h1E: other_pair = 16'h3240;
            8'h26: other_pair = 16'h3323; 8'h25: other_pair = 16'h3424;
            8'h2E: other_pair = 16'h3525; 8'h36: other_pair = 16'h365E;
            8'h3D: other_pair = 16'h3726; 8'h3E: other_pair = 16'h382A;
            8'h46: other_pair = 16'h3928; 8'h45: other_pair = 16'h3029;
            8'h0E: other_pair = 16'h607E; 8'h4E: other_pair = 16'h2D5F;
            8'h55: other_pair = 16'h3D2B; 8'h54: other_pair = 16'h5B7B;
            8'h5B: other_pair = 16'h5D7D; 8'h5D: other_pair = 16'h5C7C;
            8'h4C: other_pair = 16'h3B3A; 8'h52: other_pair = 16'h2722;
            8'h41: other_pair = 16'h2C3C; 8'h49: other_pair = 16'h2E3E;
            8'h4A: other_pair = 16'h2F3F;
            8'h29: other_pair = 16'h2020; 8'h5A: other_pair = 16'h0A0A;
            8'h66: other_pair = 16'h0808; 8'h0D: other_pair = 16'h0909;
            8'h76: other_pair = 16'h1B1B;
            default: other_pair = 16'h0000;
        endcase
    endfunction

    // {valid, ascii} for a non-modifier make code under the current modifiers.
    function automatic logic [8:0] translate(input logic [7:0] code,
                                             input logic       shift,
                                             input logic       caps);
        logic [7:0]  lc;
        logic [15:0] pr;
        lc = letter_lc(code);
        pr = other_pair(code);
        if (lc != 8'h00) begin
            translate = {1'b1, (shift ^ caps) ? (lc - 8'h20) : lc};
        end else if (pr != 16'h0000) begin
            translate = {1'b1, shift ? pr[7:0] : pr[15:8]};
        end else begin
            translate = 9'h000;
        end
    endfunction

    // ---------------- input synchronisation and glitch filter ----------------
    logic [1:0] clk_sync_r, dat_sync_r;
    logic [3:0] clk_hist_r, dat_hist_r;
    logic       clk_filt_r, dat_filt_r, clk_filt_d_r;
    logic       strobe_s;

    // Two-flop synchronisers, 4-sample filters and a delayed filtered clock.
    always_ff @(posedge clk50M) begin
        if (!rst) begin
            clk_sync_r   <= 2'b11;
            dat_sync_r   <= 2'b11;
            clk_hist_r   <= 4'hF;
            dat_hist_r   <= 4'hF;
            clk_filt_r   <= 1'b1;
            dat_filt_r   <= 1'b1;
            clk_filt_d_r <= 1'b1;
        end else begin
            clk_sync_r   <= {clk_sync_r[0], ps2_clk};
            dat_sync_r   <= {dat_sync_r[0], ps2_data};
            clk_hist_r   <= {clk_hist_r[2:0], clk_sync_r[1]};
            dat_hist_r   <= {dat_hist_r[2:0], dat_sync_r[1]};
            if (clk_hist_r == 4'hF) begin
                clk_filt_r <= 1'b1;
            end else if (clk_hist_r == 4'h0) begin
                clk_filt_r <= 1'b0;
            end
            if (dat_hist_r == 4'hF) begin
                dat_filt_r <= 1'b1;
            end else if (dat_hist_r == 4'h0) begin
                dat_filt_r <= 1'b0;
            end
            clk_filt_d_r <= clk_filt_r;
        end
    end

    assign strobe_s = clk_filt_d_r & ~clk_filt_r;

    // ---------------- frame receiver ----------------
    rx_state_t     rx_state_r;
    logic [3:0]    bit_cnt_r;
    logic [9:0]    frame_r;     // {stop, parity, data[7:0]} once complete
    logic [TW-1:0] tmo_cnt_r;
    logic          frame_err_r;
    logic          frame_ok_s;
    logic          code_valid_s;
    logic [7:0]    code_s;

    assign frame_ok_s   = (^frame_r[8:0]) & frame_r[9];
    assign code_valid_s = (rx_state_r == CHECK) && frame_ok_s;
    assign code_s       = frame_r[7:0];

    // Receiver FSM: start bit, 8 data bits LSB first, parity, stop, check.
    always_ff @(posedge clk50M) begin
        if (!rst) begin
            rx_state_r  <= IDLE;
            bit_cnt_r   <= 4'd0;
            frame_r     <= 10'd0;
            tmo_cnt_r   <= '0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            case (rx_state_r)
                IDLE: begin
                    if (strobe_s) begin
                        if (!dat_filt_r) begin
                            rx_state_r <= SHIFT;
                            bit_cnt_r  <= 4'd0;
                            tmo_cnt_r  <= '0;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (strobe_s) begin
                        frame_r   <= {dat_filt_r, frame_r[9:1]};
                        tmo_cnt_r <= '0;
                        if (bit_cnt_r == 4'd9) begin
                            rx_state_r <= CHECK;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else if (tmo_cnt_r == TO_LAST) begin
                        // Keyboard went silent mid-frame: discard the partial frame.
                        frame_err_r <= 1'b1;
                        rx_state_r  <= IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                end
                CHECK: begin
                    if (!frame_ok_s) begin
                        frame_err_r <= 1'b1;
                    end
                    rx_state_r <= IDLE;
                end
                default: rx_state_r <= IDLE;
            endcase
        end
    end

    // ---------------- scancode decoder ----------------
    logic       brk_r, ext_r, shift_l_r, shift_r_r, caps_r;
    logic       ascii_valid_r;
    logic [7:0] ascii_r;
    logic [8:0] xlat_s;

    assign xlat_s = translate(code_s, shift_l_r | shift_r_r, caps_r);

    // Prefix/modifier tracking and registered ASCII translation.
    always_ff @(posedge clk50M) begin
        if (!rst) begin
            brk_r         <= 1'b0;
            ext_r         <= 1'b0;
            shift_l_r     <= 1'b0;
            shift_r_r     <= 1'b0;
            caps_r        <= 1'b0;
            ascii_valid_r <= 1'b0;
            ascii_r       <= 8'h00;
        end else begin
            ascii_valid_r <= 1'b0;
            if (code_valid_s) begin
                if (code_s == 8'hF0) begin
                    brk_r <= 1'b1;
                end else if (code_s == 8'hE0) begin
                    ext_r <= 1'b1;
                end else begin
                    brk_r <= 1'b0;
                    ext_r <= 1'b0;
                    // Extended keys (arrows, keypad Enter, right Ctrl...) are ignored.
                    if (!ext_r) begin
                        if (code_s == 8'h12) begin
                            shift_l_r <= !brk_r;
                        end else if (code_s == 8'h59) begin
                            shift_r_r <= !brk_r;
                        end else if (code_s == 8'h58) begin
                            if (!brk_r) begin
                                caps_r <= !caps_r;
                            end
                        end else if (!brk_r) begin
                            ascii_valid_r <= xlat_s[8];
                            ascii_r       <= xlat_s[7:0];
                        end
                    end
                end
            end
        end
    end

    // ---------------- ASCII FIFO and acknowledge handshake ----------------
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
    logic [AW:0]   count_r, count_next_s, remain_s;
    logic          ack_d_r;
    logic          pop_s, push_s, full_s;
    logic          kbd_int_r, kbd_overflow_r;
    logic [7:0]    kbd_data_r, head_next_s;

    assign full_s        = (count_r == DEPTH_C);
    assign pop_s         = kbd_int_ack & ~ack_d_r & (count_r != '0);
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign push_s        = ascii_valid_r & (~full_s | pop_s);
    assign rd_ptr_next_s = pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
    assign remain_s      = count_r - {{AW{1'b0}}, pop_s};
    assign count_next_s  = remain_s + {{AW{1'b0}}, push_s};

    // Next head value; bypass the write when the new byte becomes the head.
    always_comb begin
        head_next_s = 8'h00;
        if (count_next_s == '0) begin
            head_next_s = 8'h00;
        end else if (push_s && (remain_s == '0)) begin
            head_next_s = ascii_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage, pointers, occupancy, registered head and status flags.
    always_ff @(posedge clk50M) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            ack_d_r        <= 1'b0;
            kbd_int_r      <= 1'b0;
            kbd_data_r     <= 8'h00;
            kbd_overflow_r <= 1'b0;
        end else begin
            ack_d_r <= kbd_int_ack;
            if (push_s) begin
                mem_r[wr_ptr_r] <= ascii_r;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (ascii_valid_r && !push_s) begin
                kbd_overflow_r <= 1'b1;
            end
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            kbd_int_r  <= (count_next_s != '0);
            kbd_data_r <= head_next_s;
        end
    end

    assign kbd_int       = kbd_int_r;
    assign kbd_data      = kbd_data_r;
    assign kbd_overflow  = kbd_overflow_r;
    assign kbd_frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Testbench for ps2_kbd_ascii: table-driven scancode sequences plus
// hand-written sequences for errors, timeout, overflow, ack hold,
// simultaneous push/pop and mid-frame reset.
module tb_ps2_kbd_ascii;

    localparam int TMO     = 400;        // shortened frame timeout for simulation
    localparam int HALF_NS = 10 * 20;    // PS/2 half period: 10 system clocks

    logic       clk50M = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       kbd_int;
    logic [7:0] kbd_data;
    logic       kbd_int_ack = 1'b0;
    logic       kbd_overflow;
    logic       kbd_frame_err;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    logic err_prev = 1'b0;

    ps2_kbd_ascii #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk50M(clk50M), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kbd_int(kbd_int), .kbd_data(kbd_data), .kbd_int_ack(kbd_int_ack),
        .kbd_overflow(kbd_overflow), .kbd_frame_err(kbd_frame_err)
    );

    always #10 clk50M = ~clk50M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Count error pulses and verify each lasts exactly one cycle.
    always @(negedge clk50M) begin
        if (kbd_frame_err) begin
            err_cnt++;
            check("frame_err_pulse_width", {31'd0, err_prev}, 32'd0);
        end
        err_prev = kbd_frame_err;
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #(HALF_NS);
        ps2_clk = 1'b0;
        #(HALF_NS);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] code, input int nbits, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, ~(^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        #(HALF_NS * 6);
    endtask

    task automatic send_frame(input logic [7:0] code);
        send_bits(code, 11, 1'b0);
    endtask

    task automatic wait_int(input string name);
        for (int i = 0; i < 400 && !kbd_int; i++) @(negedge clk50M);
        check(name, {31'd0, kbd_int}, 32'd1);
    endtask

    task automatic ack_pulse();
        @(negedge clk50M);
        kbd_int_ack = 1'b1;
        repeat (2) @(negedge clk50M);
        kbd_int_ack = 1'b0;
        repeat (2) @(negedge clk50M);
    endtask

    typedef struct {
        logic [47:0] codes;   // first scancode in bits [47:40]
        int          n;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int e0;
        logic found;

        vecs[0]  = '{48'h1CF01C000000, 3, 8'h61};  // a, then break a
        vecs[1]  = '{48'h121C00000000, 2, 8'h41};  // Shift+a
        vecs[2]  = '{48'hF0121C000000, 3, 8'h61};  // release Shift, a
        vecs[3]  = '{48'h581C00000000, 2, 8'h41};  // Caps on, a
        vecs[4]  = '{48'h121C00000000, 2, 8'h61};  // Caps+Shift, a
        vecs[5]  = '{48'hF01258F05816, 6, 8'h31};  // release all, caps off, 1
        vecs[6]  = '{48'h121600000000, 2, 8'h21};  // Shift+1 -> !
        vecs[7]  = '{48'hF0124E000000, 3, 8'h2D};  // -
        vecs[8]  = '{48'h125200000000, 2, 8'h22};  // Shift+' -> "
        vecs[9]  = '{48'hF0125A000000, 3, 8'h0A};  // Enter
        vecs[10] = '{48'h660000000000, 1, 8'h08};  // Backspace
        vecs[11] = '{48'h0D0000000000, 1, 8'h09};  // Tab
        vecs[12] = '{48'h760000000000, 1, 8'h1B};  // Esc
        vecs[13] = '{48'hE05AE0F05A2C, 6, 8'h74};  // extended Enter ignored, t
        vecs[14] = '{48'h051A00000000, 2, 8'h7A};  // unmapped F1, z
        vecs[15] = '{48'h594900000000, 2, 8'h3E};  // right Shift + . -> >
        vecs[16] = '{48'hF05949000000, 3, 8'h2E};  // release, .

        // Reset state
        repeat (5) @(negedge clk50M);
        check("rst_int", {31'd0, kbd_int}, 32'd0);
        check("rst_data", {24'd0, kbd_data}, 32'd0);
        check("rst_ovf", {31'd0, kbd_overflow}, 32'd0);
        check("rst_err", {31'd0, kbd_frame_err}, 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk50M);

        // Table-driven translation vectors
        for (int v = 0; v < 17; v++) begin
            for (int k = 0; k < vecs[v].n; k++) send_frame(vecs[v].codes[47 - 8 * k -: 8]);
            wait_int($sformatf("vec%0d_int", v));
            check($sformatf("vec%0d_data", v), {24'd0, kbd_data}, {24'd0, vecs[v].exp});
            ack_pulse();
            check($sformatf("vec%0d_int_after_ack", v), {31'd0, kbd_int}, 32'd0);
            check($sformatf("vec%0d_data_after_ack", v), {24'd0, kbd_data}, 32'd0);
        end

        // Bad parity: one error pulse, nothing queued
        e0 = err_cnt;
        send_bits(8'h16, 11, 1'b1);
        repeat (20) @(negedge clk50M);
        check("parity_err_cnt", err_cnt - e0, 32'd1);
        check("parity_no_push", {31'd0, kbd_int}, 32'd0);

        // Start bit of 1: error pulse
        e0 = err_cnt;
        ps2_bit(1'b1);
        repeat (20) @(negedge clk50M);
        check("start_err_cnt", err_cnt - e0, 32'd1);

        // Partial frame: timeout fires only after the quiet period
        e0 = err_cnt;
        send_bits(8'h16, 5, 1'b0);
        repeat (300) @(negedge clk50M);
        check("timeout_not_early", err_cnt - e0, 32'd0);
        for (int i = 0; i < 300 && err_cnt == e0; i++) @(negedge clk50M);
        check("timeout_err_cnt", err_cnt - e0, 32'd1);
        send_frame(8'h29);
        wait_int("after_timeout_int");
        check("after_timeout_data", {24'd0, kbd_data}, 32'h20);
        ack_pulse();

        // Overflow: 9 letters a..i, 8 kept
        check("ovf_clear_before", {31'd0, kbd_overflow}, 32'd0);
        send_frame(8'h1C); send_frame(8'h32); send_frame(8'h21);
        send_frame(8'h23); send_frame(8'h24); send_frame(8'h2B);
        send_frame(8'h34); send_frame(8'h33); send_frame(8'h43);
        check("ovf_flag", {31'd0, kbd_overflow}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain%0d_int", k), {31'd0, kbd_int}, 32'd1);
            check($sformatf("drain%0d_data", k), {24'd0, kbd_data}, 32'h61 + k);
            ack_pulse();
        end
        check("drain_empty_int", {31'd0, kbd_int}, 32'd0);
        check("drain_empty_data", {24'd0, kbd_data}, 32'd0);
        check("ovf_sticky", {31'd0, kbd_overflow}, 32'd1);

        // Ack held high 20 cycles pops exactly one of a, b, c
        send_frame(8'h1C); send_frame(8'h32); send_frame(8'h21);
        wait_int("hold_int");
        check("hold_head_before", {24'd0, kbd_data}, 32'h61);
        @(negedge clk50M);
        kbd_int_ack = 1'b1;
        repeat (20) @(negedge clk50M);
        kbd_int_ack = 1'b0;
        repeat (3) @(negedge clk50M);
        check("hold_head_after", {24'd0, kbd_data}, 32'h62);
        send_frame(8'h23);   // queue: b c d

        // Push of e coincides with pop of b: occupancy stays 3
        found = 1'b0;
        fork
            send_frame(8'h24);
            begin
                for (int i = 0; i < 2000 && !found; i++) begin
                    @(negedge clk50M);
                    if (dut.ascii_valid_r) found = 1'b1;
                end
                if (found) begin
                    kbd_int_ack = 1'b1;
                    @(negedge clk50M);
                    check("pushpop_head", {24'd0, kbd_data}, 32'h63);
                    check("pushpop_int", {31'd0, kbd_int}, 32'd1);
                    kbd_int_ack = 1'b0;
                end
            end
        join
        check("pushpop_aligned", {31'd0, found}, 32'd1);
        check("pp_c", {24'd0, kbd_data}, 32'h63);
        ack_pulse();
        check("pp_d", {24'd0, kbd_data}, 32'h64);
        ack_pulse();
        check("pp_e", {24'd0, kbd_data}, 32'h65);
        ack_pulse();
        check("pp_empty", {31'd0, kbd_int}, 32'd0);

        // Reset mid-frame with 2 entries queued
        send_frame(8'h1C); send_frame(8'h32);
        wait_int("rstq_int");
        send_bits(8'h16, 6, 1'b0);
        @(negedge clk50M);
        rst = 1'b0;
        repeat (3) @(negedge clk50M);
        check("midrst_int", {31'd0, kbd_int}, 32'd0);
        check("midrst_data", {24'd0, kbd_data}, 32'd0);
        check("midrst_ovf", {31'd0, kbd_overflow}, 32'd0);
        check("midrst_err", {31'd0, kbd_frame_err}, 32'd0);
        rst = 1'b1;
        e0 = err_cnt;
        repeat (20) @(negedge clk50M);
        send_frame(8'h5A);
        wait_int("post_rst_int");
        check("post_rst_data", {24'd0, kbd_data}, 32'h0A);
        check("post_rst_no_err", err_cnt - e0, 32'd0);
        ack_pulse();
        check("post_rst_empty", {31'd0, kbd_int}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ascii.md
Name: ps2_kbd_ascii

Overview:
- Front-end for the ASCII keyboard interface consumed by phy_mem_ctrl (kbd_data / kbd_int / kbd_int_ack).
- Receives PS/2 set-2 scancode frames from the physical keyboard and tracks make/break, extended-prefix, Shift and Caps Lock state.
- Translates make codes to 8-bit ASCII (US layout) and queues them in a small FIFO.
- Presents the FIFO head to the memory controller with a level interrupt and an acknowledge-to-pop handshake.

Parameters:
- FIFO_DEPTH, 8: ASCII FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 50000: clk50M cycles without a PS/2 falling edge before a partial frame is discarded (1 ms at 50 MHz).

Ports:
- clk50M  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- kbd_int  out  1  high while the FIFO is non-empty.
- kbd_data  out  8  ASCII byte at the FIFO head; 0x00 when empty.
- kbd_int_ack  in  1  consumer acknowledge; a rising edge pops the head.
- kbd_overflow  out  1  sticky: a translated byte was dropped because the FIFO was full.
- kbd_frame_err  out  1  one-cycle pulse on a parity, start-bit, stop-bit or timeout error.

Behaviour:
- Reset (rst=0 at a clk50M edge) clears:
  - all state, the FIFO and the flags;
  - outputs go to kbd_int=0, kbd_data=0x00, kbd_overflow=0, kbd_frame_err=0.
  - Reset mid-frame abandons the frame; no byte is produced.
- Input sync:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser, then a 4-sample glitch filter (output changes only after 4 equal consecutive samples).
  - A falling edge of the filtered clock is the bit strobe.
- Receiver FSM, states IDLE, SHIFT, CHECK:
  - IDLE: on a strobe, if data=0 (start bit), go to SHIFT with bit count 0; a start bit of 1 pulses kbd_frame_err and stays in IDLE.
  - SHIFT: capture 8 data bits LSB first, then the parity bit, then the stop bit, then go to CHECK.
  - CHECK (one cycle): valid when odd parity over data+parity holds and stop=1. A valid frame emits the scancode to the decoder the same cycle; otherwise pulse kbd_frame_err. Return to IDLE.
  - Timeout: in SHIFT, a counter resets on every strobe. Reaching TIMEOUT_CYCLES means pulse kbd_frame_err and return to IDLE.
- Decoder, on each valid scancode:
  - 0xF0: set brk.
  - 0xE0: set ext.
  - Any other code consumes and clears brk and ext.
  - 0x12 / 0x59 (left/right Shift, non-extended): shift_l / shift_r = !brk.
  - 0x58 make: toggle caps. Break: no action.
  - Breaks of all other keys produce nothing. Extended keys (ext=1) produce nothing.
- Make codes translated (US layout):
  - Letters: lowercase if (shift XOR caps)=0, else uppercase. Example: 0x1C → 'a' 0x61 / 'A' 0x41.
  - Digits 0x16..0x45: plain digits; with Shift → !@#$%^&*().
  - Punctuation keys: US-layout plain / shifted characters.
  - Fixed codes: 0x29 Space → 0x20; 0x5A Enter → 0x0A; 0x66 Backspace → 0x08; 0x0D Tab → 0x09; 0x76 Esc → 0x1B.
  - Unmapped codes produce nothing.
- Translation and push latency:
  - Translation is registered.
  - The pushed byte is visible in the FIFO 1 cycle after CHECK.
  - kbd_int and kbd_data update on the following cycle: 2 cycles from CHECK to kbd_int=1.
- FIFO:
  - Registered head output.
  - Full + push: byte dropped, kbd_overflow set (cleared only by reset).
  - Ack edge while empty: ignored.
  - Simultaneous push and pop: both happen, occupancy unchanged. The new head is presented on the next cycle.
  - After a pop, kbd_int drops for 1 cycle only when the FIFO becomes empty. Otherwise kbd_data advances to the next entry and kbd_int stays 1.
- Ack handshake:
  - Edge-detect kbd_int_ack against its registered previous value.
  - Holding ack high pops exactly one byte.
  - A second pop requires ack to return low first.

Test Plan:
- Frame 0x1C, then break 0xF0 0x1C (correct parity, 12.5 kHz PS/2 clock) → exactly one byte; kbd_int=1, kbd_data=0x61. Ack pulse → kbd_int=0, kbd_data=0x00.
- Shift (0x12), then 0x1C, then 0xF0 0x12, then 0x1C → FIFO yields 0x41 then 0x61. Caps (0x58) then 0x1C → 0x41. Caps + Shift + 0x1C → 0x61.
- Frame 0x16 with parity bit inverted → kbd_frame_err one-cycle pulse, FIFO unchanged. A frame abandoned after 5 bits → error pulse after 50000 cycles; a following good 0x29 frame → 0x20.
- FIFO_DEPTH=8: send 9 mapped make codes with no ack → 8 entries held, kbd_overflow=1. Eight ack edges drain in order; kbd_int=0 after the 8th.
- Hold kbd_int_ack high for 20 cycles with 3 entries queued → exactly one pop. A push landing in the same cycle as the pop → occupancy stays 3.
- Assert rst=0 mid-frame after 6 bits, with 2 entries queued → all outputs 0. A subsequent full 0x5A frame → kbd_data=0x0A.
